// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_entry_t    : one buffered fetch, the word's address plus the instruction word
//   RESET_PC_DEFAULT : fetch address after reset
//   PC_STEP          : byte distance between consecutive sequential fetches
//   NOP_IR           : canonical no-op encoding (addi x0, x0, 0) for consumers that need a filler
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0001_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_IR           = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO of fetch_entry_t used as the fetch queue storage.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears pointers, count and storage)
//   push      : write wr_entry at the tail (ignored when full and not popping)
//   pop       : drop the head entry (ignored when empty)
//   flush     : clear pointers and count; overrides push/pop, storage contents are kept
//   wr_entry  : entry to write on push
//   head      : storage at the read pointer (stale data when empty)
//   full      : count == DEPTH
//   empty     : count == 0
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers are exactly log2(DEPTH) bits so they wrap without explicit compares.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, captures memory words into a small
// queue of {pc, ir} pairs, and restarts at a new target on a downstream redirect.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, a word fetched into an
// empty queue is presented to decode in the same cycle (and not stored if accepted).
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   iad             : instruction address bus, always the current fetch PC
//   idt, acki_n     : instruction data, valid in the cycle acki_n is low
//   redirect_valid  : taken jump/branch; flushes the queue and reloads the fetch PC
//   redirect_pc     : redirect target (low two bits ignored)
//   out_valid/pc/ir : head of the queue toward decode
//   out_ready       : decode accepts the head this cycle
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iad,
    input  logic [31:0] idt,
    input  logic        acki_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir,
    input  logic        out_ready
);

    logic [31:0]  fetch_pc;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    logic         full;
    logic         empty;
    logic         fifo_pop;
    logic         fifo_push;
    logic         fetch_ok;

    assign iad      = fetch_pc;
    assign wr_entry = '{pc: fetch_pc, ir: idt};

    // The stored pop only depends on storage state, which keeps the full-queue
    // push decision free of a combinational loop through out_valid.
    assign fifo_pop = ~empty & out_ready;
    assign fetch_ok = ~acki_n & ~redirect_valid & (~full | fifo_pop);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;

    // An empty queue forwards the word being fetched straight to decode; it only
    // lands in storage when decode does not take it this cycle.
    assign bypass_hit = empty & fetch_ok;
    assign fifo_push  = fetch_ok & ~(bypass_hit & out_ready);
    assign out_valid  = ~empty | bypass_hit;
    assign out_pc     = bypass_hit ? fetch_pc : head.pc;
    assign out_ir     = bypass_hit ? idt      : head.ir;
`else
    assign fifo_push  = fetch_ok;
    assign out_valid  = ~empty;
    assign out_pc     = head.pc;
    assign out_ir     = head.ir;
`endif

    // The fetch PC advances whenever a word is accepted (stored or bypassed) and
    // holds otherwise, so a word dropped on a full queue is simply fetched again.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (fetch_ok) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table for the documented
// corner cases, followed by randomized traffic compared against a queue-based model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iad;
    logic [31:0] idt;
    logic        acki_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_ir;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .iad            (iad),
        .idt            (idt),
        .acki_n         (acki_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_ir         (out_ir),
        .out_ready      (out_ready)
    );

    // One directed cycle: inputs driven for the cycle and the outputs expected during it.
    // mode 0 = no check, 1 = valid+iad (+pc/ir when valid), 2 = also pc/ir when not valid.
    typedef struct {
        logic        r;
        logic        a;
        logic [31:0] d;
        logic        rv;
        logic [31:0] rp;
        logic        rdy;
        int          mode;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eir;
        logic [31:0] eiad;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } model_entry_t;

    // Reference model: the queue contents and next fetch address.
    model_entry_t mq[$];
    logic [31:0]  mpc;

    // Drive one cycle's inputs after the falling edge and let them settle.
    task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                                 input logic rv, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst            = r;
        acki_n         = a;
        idt            = d;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bypassBuild();
`ifdef FETCH_QUEUE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Compare current outputs against the model, then advance the model across the edge.
    task automatic modelCycle(input logic r, input logic a, input logic [31:0] d,
                              input logic rv, input logic [31:0] rp, input logic rdy);
        bit           was_empty;
        bit           mpop;
        bit           mpush;
        logic         ev;
        logic [31:0]  epc;
        logic [31:0]  eir;
        model_entry_t e;
        was_empty = (mq.size() == 0);
        mpop      = !was_empty && rdy;
        mpush     = !a && !rv && (mq.size() < DEPTH || mpop);
        ev  = !was_empty;
        epc = was_empty ? 32'h0 : mq[0].pc;
        eir = was_empty ? 32'h0 : mq[0].ir;
        if (bypassBuild() && was_empty && mpush) begin
            ev  = 1'b1;
            epc = mpc;
            eir = d;
        end
        checkOutput("rand_iad", iad, mpc);
        checkOutput("rand_valid", {31'b0, out_valid}, {31'b0, ev});
        if (ev) begin
            checkOutput("rand_pc", out_pc, epc);
            checkOutput("rand_ir", out_ir, eir);
        end
        if (r) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (rv) begin
            mq.delete();
            mpc = rp & ~32'h3;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                if (!(bypassBuild() && was_empty && rdy)) begin
                    e.pc = mpc;
                    e.ir = d;
                    mq.push_back(e);
                end
                mpc = mpc + 32'd4;
            end
        end
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic rv, input logic [31:0] rp, input logic rdy,
                                input int mode, input logic ev, input logic [31:0] epc,
                                input logic [31:0] eir, input logic [31:0] eiad);
        vec_t v;
        v.r = r; v.a = a; v.d = d; v.rv = rv; v.rp = rp; v.rdy = rdy;
        v.mode = mode; v.ev = ev; v.epc = epc; v.eir = eir; v.eiad = eiad;
        return v;
    endfunction

    initial begin
        rst = 1'b1; acki_n = 1'b1; idt = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

`ifndef FETCH_QUEUE_BYPASS_EN
        // Reset, then sequential streaming
        vecs.push_back(mk(1,1,32'h00,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h00,0,0,1, 2,0,32'h0,32'h0,32'h10000));
        vecs.push_back(mk(0,0,32'h11,0,0,1, 1,0,0,0,32'h10000));
        vecs.push_back(mk(0,0,32'h12,0,0,1, 1,1,32'h10000,32'h11,32'h10004));
        vecs.push_back(mk(0,0,32'h13,0,0,1, 1,1,32'h10004,32'h12,32'h10008));
        vecs.push_back(mk(0,1,32'h00,0,0,1, 1,1,32'h10008,32'h13,32'h1000c));
        // Stall decode until full, then pop and push together
        vecs.push_back(mk(0,0,32'h21,0,0,0, 1,0,0,0,32'h1000c));
        vecs.push_back(mk(0,0,32'h22,0,0,0, 1,1,32'h1000c,32'h21,32'h10010));
        vecs.push_back(mk(0,0,32'h23,0,0,0, 1,1,32'h1000c,32'h21,32'h10014));
        vecs.push_back(mk(0,0,32'h24,0,0,0, 1,1,32'h1000c,32'h21,32'h10018));
        vecs.push_back(mk(0,0,32'h25,0,0,0, 1,1,32'h1000c,32'h21,32'h1001c));
        vecs.push_back(mk(0,0,32'h26,0,0,1, 1,1,32'h1000c,32'h21,32'h1001c));
        vecs.push_back(mk(0,1,32'h00,0,0,1, 1,1,32'h10010,32'h22,32'h10020));
        // Redirect with three entries queued, unaligned target
        vecs.push_back(mk(0,0,32'h99,1,32'h20006,0, 1,1,32'h10014,32'h23,32'h10020));
        vecs.push_back(mk(0,0,32'h31,0,0,1, 1,0,0,0,32'h20004));
        vecs.push_back(mk(0,1,32'h00,0,0,1, 1,1,32'h20004,32'h31,32'h20008));
        // acki_n toggling
        vecs.push_back(mk(0,1,32'h77,0,0,0, 1,0,0,0,32'h20008));
        vecs.push_back(mk(0,0,32'h41,0,0,0, 1,0,0,0,32'h20008));
        vecs.push_back(mk(0,1,32'h78,0,0,0, 1,1,32'h20008,32'h41,32'h2000c));
        vecs.push_back(mk(0,0,32'h42,0,0,0, 1,1,32'h20008,32'h41,32'h2000c));
        // Fill, then redirect together with a full-queue pop
        vecs.push_back(mk(0,0,32'h43,0,0,0, 1,1,32'h20008,32'h41,32'h20010));
        vecs.push_back(mk(0,0,32'h44,0,0,0, 1,1,32'h20008,32'h41,32'h20014));
        vecs.push_back(mk(0,0,32'h55,1,32'h30000,1, 1,1,32'h20008,32'h41,32'h20018));
        vecs.push_back(mk(0,0,32'h51,0,0,1, 1,0,0,0,32'h30000));
        vecs.push_back(mk(0,0,32'h52,0,0,1, 1,1,32'h30000,32'h51,32'h30004));
        // Fill again, then reset with redirect asserted
        vecs.push_back(mk(0,0,32'h53,0,0,0, 1,1,32'h30004,32'h52,32'h30008));
        vecs.push_back(mk(0,0,32'h54,0,0,0, 1,1,32'h30004,32'h52,32'h3000c));
        vecs.push_back(mk(0,0,32'h55,0,0,0, 1,1,32'h30004,32'h52,32'h30010));
        vecs.push_back(mk(1,0,32'h56,1,32'h40000,1, 1,1,32'h30004,32'h52,32'h30014));
        vecs.push_back(mk(0,1,32'h00,0,0,0, 2,0,32'h0,32'h0,32'h10000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
            if (vecs[i].mode != 0) begin
                checkOutput($sformatf("vec%0d_iad", i), iad, vecs[i].eiad);
                checkOutput($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
                if (vecs[i].ev || vecs[i].mode == 2) begin
                    checkOutput($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
                    checkOutput($sformatf("vec%0d_ir", i), out_ir, vecs[i].eir);
                end
            end
        end
`else
        // Same-cycle forwarding into decode when the queue is empty
        applyStimulus(1, 1, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h0, 0, 32'h0, 0);
        checkOutput("byp_reset_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("byp_reset_pc", out_pc, 32'h0);
        checkOutput("byp_reset_ir", out_ir, 32'h0);
        checkOutput("byp_reset_iad", iad, RESET_PC);
        applyStimulus(0, 0, 32'h0050_0093, 0, 32'h0, 1);
        checkOutput("byp_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("byp_ir", out_ir, 32'h0050_0093);
        checkOutput("byp_pc", out_pc, RESET_PC);
        applyStimulus(0, 1, 32'h0, 0, 32'h0, 1);
        checkOutput("byp_consumed_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("byp_consumed_iad", iad, RESET_PC + 32'd4);
`endif

        // Randomized traffic against the reference model
        applyStimulus(1, 1, 32'h0, 0, 32'h0, 0);
        mq.delete();
        mpc = RESET_PC;
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic        a;
            logic [31:0] d;
            logic        rv;
            logic [31:0] rp;
            logic        rdy;
            r   = ($urandom_range(0, 99) == 0);
            a   = ($urandom_range(0, 99) < 40);
            d   = $urandom;
            rv  = ($urandom_range(0, 99) < 5);
            rp  = $urandom;
            rdy = ($urandom_range(0, 99) < 55);
            applyStimulus(r, a, d, rv, rp, rdy);
            modelCycle(r, a, d, rv, rp, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
